mem_dump: RTL
=============

Name: mem_dump

Overview:
- Sequential memory read-back engine, the reading end of the bench memory-load path.
- After a program run it scans a contiguous address range of the unified 16-bit memory and streams each word out over a valid/ready handshake. Bench checkers or a future UART/debug port consume the stream.
- Drives the same address/mrw interface the loader drives; memory read is combinational (memout = mem[addr]).

Parameters:
- AW, 16, address width (matches marval).
- DW, 16, data width (matches memout).

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a dump; sampled in IDLE only.
- base  in  AW  first address; sampled on accepted start.
- count  in  AW  number of words to read; sampled on accepted start.
- maxmem  in  AW  highest legal address (from memory.maxmem).
- mem_addr  out  AW  address to memory (muxed onto amarval by the top).
- mem_rw  out  1  memory write enable; constant 0.
- memout  in  DW  combinational read data for mem_addr.
- out_data  out  DW  streamed word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_last  out  1  marks final word of the dump; qualified by out_valid.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when the dump finishes.
- err  out  1  sticky range error; cleared by the next accepted start.

Behaviour:
- Reset values: mem_addr=0, mem_rw=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, err=0. FSM goes to IDLE. Reset mid-dump aborts immediately with no done pulse.
- FSM states:
  - IDLE: on start, latch addr=base and rem=count, clear err.
    - If count==0: go to FIN.
    - If base>maxmem: set err, go to FIN.
    - Otherwise go to READ.
  - READ: mem_addr=addr. Capture condition is (!out_valid || out_ready) && rem!=0. On capture:
    - out_data<=memout, out_valid<=1, out_last<=(rem==1).
    - addr<=addr+1, rem<=rem-1.
    - If addr==maxmem and rem>1: set err, force out_last<=1, and stop further captures.
  - DRAIN: entered once the last word is captured; wait until out_valid && out_ready, then drop out_valid and go to FIN.
  - FIN: done=1 for one cycle, busy=0, go to IDLE.
- Handshake and latency:
  - Word N appears one cycle after its address is presented.
  - Throughput is 1 word/cycle while out_ready=1.
  - out_valid, out_data and out_last stay stable while out_valid && !out_ready.
  - A new capture may occur in the same cycle the previous word is accepted (no bubble).
- busy=1 in READ and DRAIN. start is ignored while busy.
- Address arithmetic is AW-bit unsigned. A dump never wraps past maxmem; it truncates with err instead.
- mem_rw stays 0 at all times, so the block can never corrupt memory.

Optional Feature:
- Macro: MEM_DUMP_CHECKSUM_EN.
- Enabled:
  - Adds output csum[DW-1:0]: the modulo-2^DW sum of every accepted word (out_valid && out_ready).
  - csum clears on accepted start and is stable from done onward until the next start.
- Disabled: port csum is absent and no adder is synthesized.

Decomposition:
- Shared package/include (mem_pkg): state encodings IDLE/READ/DRAIN/FIN, AW/DW defaults, and MAXMEMORY (4095), the same constant the memory uses.
- One natural sub-module, dump_outreg: a single-entry output holding register with valid/ready, data and last. The FSM and address counter stay in mem_dump.

Test Plan:
1. Preload mem[0..3]=16'hB010,16'hEA00,16'hB000,16'hB000; base=0, count=4, out_ready=1.
   - Required: 4 words on consecutive cycles, out_last only on 16'hB000 at addr 3, done one cycle after the last accept, err=0.
2. Same dump with out_ready toggling 1,0,0,1,...
   - Required: no word lost or duplicated; out_data/out_last held during stalls; order preserved.
3. count=0.
   - Required: out_valid never asserts, done pulses 2 cycles after start, err=0.
4. base=4094, count=4, maxmem=4095.
   - Required: exactly 2 words (addrs 4094, 4095); the second has out_last=1; err=1 at done.
   - Then base=5000: zero words, err=1. Then a valid start clears err.
5. Reset asserted mid-dump after 2 words.
   - Required: all outputs return to reset values next cycle, no done pulse; a fresh start works normally.
6. MEM_DUMP_CHECKSUM_EN defined, mem[0..2]=16'hFFFF,16'h0002,16'h0010, count=3.
   - Required: csum=16'h0011 at done.
   - Also: a start issued while busy is ignored, with no change to the stream.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, memory size and dump FSM state encoding
package mem_pkg;
  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;
  localparam int MAXMEMORY = 4095;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;
endpackage

// File: rtl/mem_dump_outreg.sv
// dump_outreg: single-entry output holding register with valid/ready, data and last
module dump_outreg #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic          i_last,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_last
);
  logic          r_valid;
  logic [DW-1:0] r_data;
  logic          r_last;
  // load overwrites the entry (caller only loads when empty or being accepted); accept without load empties it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
endmodule

// File: rtl/mem_dump.sv
// mem_dump: scans a memory range and streams each word over valid/ready; MEM_DUMP_CHECKSUM_EN adds a running csum output
module mem_dump
  import mem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] count,
  input  logic [AW-1:0] maxmem,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rw,
  input  logic [DW-1:0] memout,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          err
`ifdef MEM_DUMP_CHECKSUM_EN
  ,
  output logic [DW-1:0] csum
`endif
);
  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_rem;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic          w_valid;
  logic [DW-1:0] w_data;
  logic          w_last;
  logic          w_cap;
  logic          w_end;
  assign w_cap = (r_state == READ) && (!w_valid || out_ready) && (r_rem != '0);
  assign w_end = (r_rem == AW'(1)) || (r_addr == maxmem);
  dump_outreg #(.DW(DW)) u_outreg (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_cap),
    .i_data (memout),
    .i_last (w_end),
    .i_ready(out_ready),
    .o_valid(w_valid),
    .o_data (w_data),
    .o_last (w_last)
  );
  // dump sequencer: range check on start, one capture per free output slot, truncate at maxmem with err
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_addr  <= base;
          r_rem   <= count;
          r_err   <= (count != '0) && (base > maxmem);
          r_busy  <= (count != '0) && (base <= maxmem);
          r_state <= (count == '0 || base > maxmem) ? FIN : READ;
        end
        READ: if (w_cap) begin
          r_addr <= r_addr + AW'(1);
          r_rem  <= r_rem - AW'(1);
          if (w_end) begin
            r_state <= DRAIN;
            r_err   <= r_err | (r_rem != AW'(1));
          end
        end
        DRAIN: if (w_valid && out_ready) begin
          r_state <= FIN;
          r_busy  <= 1'b0;
        end
        FIN: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [DW-1:0] r_csum;
  // running sum of accepted words, restarted by an accepted start
  always_ff @(posedge clk) begin
    if (reset) r_csum <= '0;
    else if (r_state == IDLE && start) r_csum <= '0;
    else if (w_valid && out_ready) r_csum <= r_csum + w_data;
  end
  assign csum = r_csum;
`endif
  assign mem_addr  = r_addr;
  assign mem_rw    = 1'b0;
  assign out_data  = w_data;
  assign out_valid = w_valid;
  assign out_last  = w_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
endmodule
